// File: rtl/math_divider_radix_4.sv
// Signed radix-4 restoring divider, two quotient bits per cycle.
// Truncates toward zero and flags divide-by-zero and overflow.
module math_divider_radix_4 #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_div_by_zero,
    output logic         o_overflow
);

    localparam int W  = N + 2;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  p;
    logic [W-1:0]  d;
    logic [W-1:0]  d3;
    logic [N-1:0]  a;
    logic [N-1:0]  q;
    logic          neg_q;
    logic          neg_r;

    logic [N-1:0]  dvd_abs;
    logic [N-1:0]  dvs_abs;
    logic          is_min;
    logic          is_m1;
    logic [W-1:0]  p_sh;
    logic [W-1:0]  d2;
    logic [W-1:0]  p_nx;
    logic [1:0]    digit;
    logic [N-1:0]  q_nx;
    logic [N-1:0]  r_nx;
    logic [N-1:0]  q_fin;
    logic [N-1:0]  r_fin;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);

    assign dvd_abs = i_dividend[N-1] ? -i_dividend : i_dividend;
    assign dvs_abs = i_divisor[N-1] ? -i_divisor : i_divisor;
    assign is_min  = (i_dividend == {1'b1, {(N-1){1'b0}}});
    assign is_m1   = &i_divisor;

    // Next partial remainder pulls in the next two dividend bits
    assign p_sh = (p << 2) | W'(a[N-1:N-2]);
    assign d2   = d << 1;

    always_comb begin
        digit = 2'd0;
        p_nx  = p_sh;
        if (p_sh >= d3) begin
            digit = 2'd3;
            p_nx  = p_sh - d3;
        end else if (p_sh >= d2) begin
            digit = 2'd2;
            p_nx  = p_sh - d2;
        end else if (p_sh >= d) begin
            digit = 2'd1;
            p_nx  = p_sh - d;
        end
    end

    assign q_nx  = {q[N-3:0], digit};
    assign r_nx  = N'(p_nx);
    assign q_fin = neg_q ? -q_nx : q_nx;
    assign r_fin = neg_r ? -r_nx : r_nx;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            p             <= '0;
            d             <= '0;
            d3            <= '0;
            a             <= '0;
            q             <= '0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    if (i_divisor == '0) begin
                        state         <= DONE;
                        o_quotient    <= '1;
                        o_remainder   <= i_dividend;
                        o_div_by_zero <= 1'b1;
                        o_overflow    <= 1'b0;
                    end else if (is_min && is_m1) begin
                        state         <= DONE;
                        o_quotient    <= i_dividend;
                        o_remainder   <= '0;
                        o_div_by_zero <= 1'b0;
                        o_overflow    <= 1'b1;
                    end else begin
                        state <= CALC;
                        cnt   <= '0;
                        p     <= '0;
                        q     <= '0;
                        a     <= dvd_abs;
                        d     <= W'(dvs_abs);
                        d3    <= W'(dvs_abs) + (W'(dvs_abs) << 1);
                        neg_q <= i_dividend[N-1] ^ i_divisor[N-1];
                        neg_r <= i_dividend[N-1];
                    end
                end
                CALC: begin
                    p   <= p_nx;
                    q   <= q_nx;
                    a   <= a << 2;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state         <= DONE;
                        o_quotient    <= q_fin;
                        o_remainder   <= r_fin;
                        o_div_by_zero <= 1'b0;
                        o_overflow    <= 1'b0;
                    end
                end
                DONE: if (i_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_math_divider_radix_4.sv
// Directed bench for the radix-4 divider at N=8.
// Vectors carry hand-computed quotient, remainder, flags and latency.
module tb_math_divider_radix_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv;
    logic       ordy;
    logic [7:0] dvd;
    logic [7:0] dvs;
    logic       ov;
    logic       irdy;
    logic [7:0] quo;
    logic [7:0] rem;
    logic       dz;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    math_divider_radix_4 #(.N(8)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_valid(iv),
        .o_ready(ordy),
        .i_dividend(dvd),
        .i_divisor(dvs),
        .o_valid(ov),
        .i_ready(irdy),
        .o_quotient(quo),
        .o_remainder(rem),
        .o_div_by_zero(dz),
        .o_overflow(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operand pair; returns with the accept edge just taken
    task automatic accept(input logic [7:0] a, input logic [7:0] b,
                          input string tag);
        int w;
        w = 0;
        while (!ordy && w < 20) begin
            step();
            w++;
        end
        chk({tag, "_ready"}, 32'(ordy), 32'd1);
        iv  = 1'b1;
        dvd = a;
        dvs = b;
        step();
        iv  = 1'b0;
        dvd = 8'h5A;
        dvs = 8'h00;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!ov && lat < 30) begin
            step();
            lat++;
        end
    endtask

    task automatic div(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er,
                       input logic edz, input logic eov,
                       input int elat, input string tag);
        int lat;
        accept(a, b, tag);
        wait_valid(lat);
        chk({tag, "_lat"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(quo), 32'(eq));
        chk({tag, "_r"}, 32'(rem), 32'(er));
        chk({tag, "_dz"}, 32'(dz), 32'(edz));
        chk({tag, "_ov"}, 32'(ovf), 32'(eov));
        chk({tag, "_rdy_done"}, 32'(ordy), 32'd0);
        step();
        chk({tag, "_idle"}, {31'd0, ov}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [17:0] snap;
        rst  = 1'b1;
        iv   = 1'b0;
        dvd  = '0;
        dvs  = '0;
        irdy = 1'b1;
        step();
        step();
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_q", 32'(quo), 32'd0);
        chk("rst_r", 32'(rem), 32'd0);
        chk("rst_flags", 32'({dz, ovf}), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(ordy), 32'd1);

        div(8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 5, "p100_7");
        div(8'h9C, 8'd7, 8'hF2, 8'hFE, 1'b0, 1'b0, 5, "n100_7");
        div(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, 5, "p100_n7");
        div(8'd17, 8'h00, 8'hFF, 8'h11, 1'b1, 1'b0, 1, "dz17");
        div(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1, "ovf");
        div(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 5, "min_1");
        div(8'hF9, 8'd2, 8'hFD, 8'hFF, 1'b0, 1'b0, 5, "n7_2");
        div(8'd127, 8'h80, 8'h00, 8'h7F, 1'b0, 1'b0, 5, "max_min");
        div(8'h80, 8'h80, 8'h01, 8'h00, 1'b0, 1'b0, 5, "min_min");
        div(8'h80, 8'd7, 8'hEE, 8'hFE, 1'b0, 1'b0, 5, "min_7");
        div(8'd0, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0, 5, "zero_5");

        // Consumer stalls: result must hold steady and no new accept
        irdy = 1'b0;
        accept(8'd100, 8'd7, "hold");
        wait_valid(lat);
        chk("hold_lat", 32'(lat), 32'd5);
        snap = {ov, ordy, quo, rem};
        chk("hold_val", 32'(snap), 32'({1'b1, 1'b0, 8'h0E, 8'h02}));
        iv  = 1'b1;
        dvd = 8'd45;
        dvs = 8'd6;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hold_stable", 32'({ov, ordy, quo, rem, dz, ovf}),
                32'({snap, 2'b00}));
        end
        iv   = 1'b0;
        irdy = 1'b1;
        step();
        chk("hold_release_valid", 32'(ov), 32'd0);
        chk("hold_release_ready", 32'(ordy), 32'd1);
        chk("hold_release_q", 32'(quo), 32'h0E);

        // Reset two edges into CALC discards the operation
        accept(8'd100, 8'd7, "midrst");
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", 32'(ov), 32'd0);
        chk("midrst_ready", 32'(ordy), 32'd1);
        chk("midrst_out", 32'({quo, rem, dz, ovf}), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_noresult", 32'(ov), 32'd0);
        end
        div(8'd45, 8'd6, 8'h07, 8'h03, 1'b0, 1'b0, 5, "p45_6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
